// File: rtl/id_branch_ctrl.sv
// ID-stage branch hazard/sequencing controller: stalls on RAW hazards, drives comparator forwarding, issues PC redirect + IF/ID flush.
// Optional statistics counters are enabled with `define ID_BRANCH_STATS_EN.
module id_branch_ctrl #(
  parameter int REG_AW  = 5,
  parameter int STALL_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [2:0]        i_con_bop,
  input  logic [REG_AW-1:0] i_rs_addr,
  input  logic [REG_AW-1:0] i_rt_addr,
  input  logic              i_ex_regwrite,
  input  logic              i_ex_memread,
  input  logic [REG_AW-1:0] i_ex_wreg,
  input  logic              i_mem_regwrite,
  input  logic              i_mem_memread,
  input  logic [REG_AW-1:0] i_mem_wreg,
  input  logic              i_hold,
  input  logic              i_con_ifbranch,
  output logic [1:0]        o_fwd_rs,
  output logic [1:0]        o_fwd_rt,
  output logic              o_stall,
  output logic              o_pc_sel,
  output logic              o_flush_ifid
`ifdef ID_BRANCH_STATS_EN
  ,
  output logic [31:0]       o_stat_branches,
  output logic [31:0]       o_stat_taken,
  output logic [31:0]       o_stat_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESOLVE
  } state_e;

  state_e             state_q, state_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  logic               br;
  logic               ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
  logic               ex_hit, mem_hit;
  logic [STALL_W-1:0] need;
  logic               fwd_rs_hit, fwd_rt_hit;
  logic               resolve;
  logic               stall;

  // Hazard detection against the EX and MEM destinations; register 0 never hazards.
  always_comb begin
    br         = (i_con_bop inside {[3'd1:3'd6]});
    ex_rs_hit  = i_ex_regwrite && (i_ex_wreg == i_rs_addr) && (i_rs_addr != '0);
    ex_rt_hit  = i_ex_regwrite && (i_ex_wreg == i_rt_addr) && (i_rt_addr != '0);
    mem_rs_hit = i_mem_regwrite && (i_mem_wreg == i_rs_addr) && (i_rs_addr != '0);
    mem_rt_hit = i_mem_regwrite && (i_mem_wreg == i_rt_addr) && (i_rt_addr != '0);
    ex_hit     = ex_rs_hit || ex_rt_hit;
    mem_hit    = mem_rs_hit || mem_rt_hit;

    need = '0;
    if (ex_hit && i_ex_memread) begin
      need = STALL_W'(2);
    end else if (ex_hit) begin
      need = STALL_W'(1);
    end else if (mem_hit && i_mem_memread) begin
      need = STALL_W'(1);
    end

    fwd_rs_hit = mem_rs_hit && !i_mem_memread;
    fwd_rt_hit = mem_rt_hit && !i_mem_memread;
  end

  // Next-state and stall sequencing; a hold freezes all sequencing state.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    stall       = 1'b0;
    resolve     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (br) begin
          if (need == '0) begin
            resolve = 1'b1;
          end else begin
            stall       = 1'b1;
            stall_cnt_d = need - STALL_W'(1);
            state_d     = (need == STALL_W'(2)) ? S_WAIT : S_RESOLVE;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (stall_cnt_q <= STALL_W'(1)) begin
          stall_cnt_d = '0;
          state_d     = S_RESOLVE;
        end else begin
          stall_cnt_d = stall_cnt_q - STALL_W'(1);
        end
      end
      S_RESOLVE: begin
        resolve = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        stall_cnt_d = '0;
      end
    endcase

    if (i_hold) begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  always_comb begin
    o_fwd_rs     = 2'b00;
    o_fwd_rt     = 2'b00;
    o_stall      = 1'b0;
    o_pc_sel     = 1'b0;
    o_flush_ifid = 1'b0;
    if (i_rst_n) begin
      o_stall = stall;
      if (resolve) begin
        o_fwd_rs     = {1'b0, fwd_rs_hit};
        o_fwd_rt     = {1'b0, fwd_rt_hit};
        o_pc_sel     = i_con_ifbranch && !i_hold;
        o_flush_ifid = i_con_ifbranch && !i_hold;
      end
    end
  end

`ifdef ID_BRANCH_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_taken_q, stat_taken_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_taken_d    = stat_taken_q;
    stat_stall_d    = stat_stall_q;
    if (!i_hold) begin
      if (resolve) begin
        stat_branches_d = stat_branches_q + 32'd1;
        if (i_con_ifbranch) begin
          stat_taken_d = stat_taken_q + 32'd1;
        end
      end
      if (stall) begin
        stat_stall_d = stat_stall_q + 32'd1;
      end
    end
  end

  assign o_stat_branches = stat_branches_q;
  assign o_stat_taken    = stat_taken_q;
  assign o_stat_stall    = stat_stall_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= S_IDLE;
      stall_cnt_q     <= '0;
`ifdef ID_BRANCH_STATS_EN
      stat_branches_q <= '0;
      stat_taken_q    <= '0;
      stat_stall_q    <= '0;
`endif
    end else begin
      state_q         <= state_d;
      stall_cnt_q     <= stall_cnt_d;
`ifdef ID_BRANCH_STATS_EN
      stat_branches_q <= stat_branches_d;
      stat_taken_q    <= stat_taken_d;
      stat_stall_q    <= stat_stall_d;
`endif
    end
  end

endmodule
